mgmt_sram_ctrl: RTL and testbench

MGMT_SRAM_CTRL -- requirements
Module: mgmt_sram_ctrl

---
 rtl/mgmt_sram_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mgmt_sram_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_sram_ctrl.sv
// mgmt_sram_ctrl: Wishbone classic slave bridging to a single-port,
// clock-synchronous SRAM macro (csb/web/wmask/addr/din sampled on rising
// edge, dout valid after the following falling edge).
// Optional feature: define SRAM_CTRL_RDBUF_EN for a one-word read buffer
// that answers repeat reads of the last-read word without an SRAM access.
module mgmt_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0100_0000,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  sram_clk0,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [31:0]           sram_din0,
  input  logic [31:0]           sram_dout0
);

  localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_csb, w_csb_nxt;
  logic                  r_web, w_web_nxt;
  logic [3:0]            r_wmask, w_wmask_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [31:0]           r_din, w_din_nxt;
  logic [31:0]           r_dat, w_dat_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_we, w_we_nxt;
  logic                  r_abort, w_abort_nxt;

  logic                  w_hit;
  logic                  w_drop;
  logic                  w_short;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic                  w_unused_adr;

`ifdef SRAM_CTRL_RDBUF_EN
  logic                  r_bhit, w_bhit_nxt;
  logic                  r_bvalid, w_bvalid_nxt;
  logic [ADDR_WIDTH-1:0] r_baddr, w_baddr_nxt;
  logic [31:0]           r_bdata, w_bdata_nxt;
`endif

  assign sram_clk0    = wb_clk_i;
  assign w_word_addr  = wb_adr_i[TAG_LSB-1:2];
  assign w_unused_adr = ^wb_adr_i[1:0];
  assign w_hit        = wb_cyc_i & wb_stb_i &
                        (wb_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  // Once the master has let go, the access still runs to completion but
  // must not be acknowledged.
  assign w_drop       = r_abort | ~(wb_cyc_i & wb_stb_i);

`ifdef SRAM_CTRL_RDBUF_EN
  assign w_short = r_we | r_bhit;
`else
  assign w_short = r_we;
`endif

  assign sram_csb0   = r_csb;
  assign sram_web0   = r_web;
  assign sram_wmask0 = r_wmask;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;
  assign wb_dat_o    = r_dat;
  assign wb_ack_o    = r_ack;

  // Next-state and next-output decode for the IDLE/ISSUE/WAIT/ACK sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_csb_nxt   = r_csb;
    w_web_nxt   = r_web;
    w_wmask_nxt = r_wmask;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_dat_nxt   = r_dat;
    w_ack_nxt   = 1'b0;
    w_we_nxt    = r_we;
    w_abort_nxt = r_abort;
`ifdef SRAM_CTRL_RDBUF_EN
    w_bhit_nxt   = r_bhit;
    w_bvalid_nxt = r_bvalid;
    w_baddr_nxt  = r_baddr;
    w_bdata_nxt  = r_bdata;
`endif
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_state_nxt = ISSUE;
          w_we_nxt    = wb_we_i;
          w_abort_nxt = 1'b0;
          w_web_nxt   = ~wb_we_i;
          w_addr_nxt  = w_word_addr;
          w_din_nxt   = wb_dat_i;
          w_wmask_nxt = wb_sel_i;
          // A write with no byte lanes selected never touches the macro.
          w_csb_nxt   = (wb_we_i && (wb_sel_i == '0)) ? 1'b1 : 1'b0;
`ifdef SRAM_CTRL_RDBUF_EN
          w_bhit_nxt = ~wb_we_i & r_bvalid & (r_baddr == w_word_addr);
          if (w_bhit_nxt) begin
            w_csb_nxt = 1'b1;
          end
          if (wb_we_i && (r_baddr == w_word_addr)) begin
            w_bvalid_nxt = 1'b0;
          end
`endif
        end
      end
      ISSUE: begin
        w_csb_nxt   = 1'b1;
        w_web_nxt   = 1'b1;
        w_abort_nxt = w_drop;
        if (w_short) begin
          w_state_nxt = ACK;
          w_ack_nxt   = ~w_drop;
`ifdef SRAM_CTRL_RDBUF_EN
          if (r_bhit) begin
            w_dat_nxt = r_bdata;
          end
`endif
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_dat_nxt   = sram_dout0;
        w_ack_nxt   = ~w_drop;
        w_abort_nxt = w_drop;
        w_state_nxt = ACK;
`ifdef SRAM_CTRL_RDBUF_EN
        w_bvalid_nxt = 1'b1;
        w_baddr_nxt  = r_addr;
        w_bdata_nxt  = sram_dout0;
`endif
      end
      ACK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered SRAM/Wishbone outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_dat   <= '0;
      r_ack   <= 1'b0;
      r_we    <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_csb   <= w_csb_nxt;
      r_web   <= w_web_nxt;
      r_wmask <= w_wmask_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      r_dat   <= w_dat_nxt;
      r_ack   <= w_ack_nxt;
      r_we    <= w_we_nxt;
      r_abort <= w_abort_nxt;
    end
  end

`ifdef SRAM_CTRL_RDBUF_EN
  // One-word read buffer: address, data, valid and the per-access hit flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_bhit   <= 1'b0;
      r_bvalid <= 1'b0;
      r_baddr  <= '0;
      r_bdata  <= '0;
    end else begin
      r_bhit   <= w_bhit_nxt;
      r_bvalid <= w_bvalid_nxt;
      r_baddr  <= w_baddr_nxt;
      r_bdata  <= w_bdata_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mgmt_sram_ctrl.sv
// Directed testbench for mgmt_sram_ctrl with a behavioural SRAM macro model.
module tb_mgmt_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i, dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        sram_clk0, sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mgmt_sram_ctrl #(
    .BASE_ADDR (32'h0100_0000),
    .ADDR_WIDTH(9)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we_i),
    .wb_sel_i   (sel_i),
    .wb_adr_i   (adr_i),
    .wb_dat_i   (dat_i),
    .wb_dat_o   (dat_o),
    .wb_ack_o   (ack_o),
    .sram_clk0  (sram_clk0),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  // SRAM macro model: controls sampled on rising edge, acted on at falling edge.
  logic [31:0] mem [0:511];
  logic        s_csb = 1'b1;
  logic        s_web;
  logic [8:0]  s_addr;
  logic [31:0] s_din;
  logic [3:0]  s_mask;

  always @(posedge sram_clk0) begin
    s_csb  <= sram_csb0;
    s_web  <= sram_web0;
    s_addr <= sram_addr0;
    s_din  <= sram_din0;
    s_mask <= sram_wmask0;
  end

  always @(negedge sram_clk0) begin
    if (s_csb === 1'b0) begin
      if (s_web === 1'b0) begin
        for (int b = 0; b < 4; b++)
          if (s_mask[b]) mem[s_addr][8*b +: 8] = s_din[8*b +: 8];
      end else begin
        sram_dout0 = mem[s_addr];
      end
    end
  end

  // One Wishbone transfer, bounded at 10 cycles; reports when ack arrived.
  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat,
                         input logic we, input logic [3:0] sel,
                         output int ack_cyc, output logic [31:0] rdata,
                         output int csb_cnt, output logic [8:0] last_addr,
                         output logic last_web, output logic ack_after);
    cyc = 1'b1; stb = 1'b1; we_i = we; sel_i = sel; adr_i = adr; dat_i = dat;
    ack_cyc = 0; rdata = '0; csb_cnt = 0; last_addr = '0; last_web = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (sram_csb0 === 1'b0) begin
        csb_cnt++;
        last_addr = sram_addr0;
        last_web  = sram_web0;
      end
      if (ack_o === 1'b1) begin
        ack_cyc = n;
        rdata   = dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we_i = 1'b0; sel_i = '0;
    @(posedge clk); #1;
    ack_after = ack_o;
  endtask

  int          a_cyc, c_cnt;
  logic [31:0] rd;
  logic [8:0]  l_addr;
  logic        l_web, a_after;

  task automatic test_reset();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we_i = 1'b0; sel_i = '0; adr_i = '0; dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (sram_csb0 !== 1'b1) begin miscompares++; $display("FAIL rst_csb: got %b expected 1", sram_csb0); end
    vectors++; if (sram_web0 !== 1'b1) begin miscompares++; $display("FAIL rst_web: got %b expected 1", sram_web0); end
    vectors++; if (sram_wmask0 !== 4'h0) begin miscompares++; $display("FAIL rst_wmask: got %h expected 0", sram_wmask0); end
    vectors++; if (sram_addr0 !== 9'h0) begin miscompares++; $display("FAIL rst_addr: got %h expected 0", sram_addr0); end
    vectors++; if (sram_din0 !== 32'h0) begin miscompares++; $display("FAIL rst_din: got %h expected 0", sram_din0); end
    vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL rst_dat_o: got %h expected 0", dat_o); end
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %b expected 0", ack_o); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    wb_xfer(32'h0100_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (a_cyc !== 2) begin miscompares++; $display("FAIL wr_ack_cycle: got %0d expected 2", a_cyc); end
    vectors++; if (c_cnt !== 1) begin miscompares++; $display("FAIL wr_csb_cycles: got %0d expected 1", c_cnt); end
    vectors++; if (l_addr !== 9'd4) begin miscompares++; $display("FAIL wr_sram_addr: got %0d expected 4", l_addr); end
    vectors++; if (l_web !== 1'b0) begin miscompares++; $display("FAIL wr_web: got %b expected 0", l_web); end
    vectors++; if (a_after !== 1'b0) begin miscompares++; $display("FAIL wr_ack_width: got %b expected 0", a_after); end
    wb_xfer(32'h0100_0010, 32'h0, 1'b0, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (a_cyc !== 3) begin miscompares++; $display("FAIL rd_ack_cycle: got %0d expected 3", a_cyc); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    vectors++; if (c_cnt !== 1) begin miscompares++; $display("FAIL rd_csb_cycles: got %0d expected 1", c_cnt); end
    vectors++; if (l_addr !== 9'd4) begin miscompares++; $display("FAIL rd_sram_addr: got %0d expected 4", l_addr); end
    vectors++; if (l_web !== 1'b1) begin miscompares++; $display("FAIL rd_web: got %b expected 1", l_web); end
    vectors++; if (a_after !== 1'b0) begin miscompares++; $display("FAIL rd_ack_width: got %b expected 0", a_after); end
  endtask

  task automatic test_byte_mask();
    wb_xfer(32'h0100_0040, 32'hFFFF_FFFF, 1'b1, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    wb_xfer(32'h0100_0040, 32'h0000_0011, 1'b1, 4'b0001, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (a_cyc !== 2) begin miscompares++; $display("FAIL mask_wr_ack: got %0d expected 2", a_cyc); end
    wb_xfer(32'h0100_0040, 32'h0, 1'b0, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (rd !== 32'hFFFF_FF11) begin miscompares++; $display("FAIL mask_rd_data: got %h expected ffffff11", rd); end
  endtask

  task automatic test_zero_sel();
    wb_xfer(32'h0100_0040, 32'h0, 1'b1, 4'b0000, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (a_cyc !== 2) begin miscompares++; $display("FAIL zsel_ack: got %0d expected 2", a_cyc); end
    vectors++; if (c_cnt !== 0) begin miscompares++; $display("FAIL zsel_csb: got %0d expected 0", c_cnt); end
    wb_xfer(32'h0100_0040, 32'h0, 1'b0, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (rd !== 32'hFFFF_FF11) begin miscompares++; $display("FAIL zsel_rd_data: got %h expected ffffff11", rd); end
  endtask

  task automatic test_miss();
    wb_xfer(32'h0200_0000, 32'h1, 1'b1, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (a_cyc !== 0) begin miscompares++; $display("FAIL miss_ack: got %0d expected 0", a_cyc); end
    vectors++; if (c_cnt !== 0) begin miscompares++; $display("FAIL miss_csb: got %0d expected 0", c_cnt); end
  endtask

  task automatic test_reset_in_wait();
    cyc = 1'b1; stb = 1'b1; we_i = 1'b0; sel_i = 4'hF; adr_i = 32'h0100_0010;
    @(posedge clk); #1;
    vectors++; if (sram_csb0 !== 1'b0) begin miscompares++; $display("FAIL rw_issue_csb: got %b expected 0", sram_csb0); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL rw_ack: got %b expected 0", ack_o); end
    vectors++; if (sram_csb0 !== 1'b1) begin miscompares++; $display("FAIL rw_csb: got %b expected 1", sram_csb0); end
    vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL rw_dat_o: got %h expected 0", dat_o); end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL rw_ack_later: got %b expected 0", ack_o); end
    rst = 1'b0;
    @(posedge clk); #1;
    wb_xfer(32'h0100_0010, 32'h0, 1'b0, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (a_cyc !== 3) begin miscompares++; $display("FAIL rw_next_ack: got %0d expected 3", a_cyc); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rw_next_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_stb_drop();
    int acks;
    acks = 0;
    cyc = 1'b1; stb = 1'b1; we_i = 1'b1; sel_i = 4'hF; adr_i = 32'h0100_0030; dat_i = 32'h1234_5678;
    @(posedge clk); #1;
    vectors++; if (sram_csb0 !== 1'b0) begin miscompares++; $display("FAIL drop_csb: got %b expected 0", sram_csb0); end
    cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack_o === 1'b1) acks++;
    end
    vectors++; if (acks !== 0) begin miscompares++; $display("FAIL drop_ack: got %0d acks expected 0", acks); end
    wb_xfer(32'h0100_0030, 32'h0, 1'b0, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL drop_rd_data: got %h expected 12345678", rd); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ack_bits, csb_bits;
    ack_bits = '0; csb_bits = '0;
    cyc = 1'b1; stb = 1'b1; we_i = 1'b1; sel_i = 4'hF; adr_i = 32'h0100_0050; dat_i = 32'h0BAD_F00D;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      ack_bits[n] = ack_o;
      csb_bits[n] = ~sram_csb0;
    end
    cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if (ack_bits !== 6'b010010) begin miscompares++; $display("FAIL b2b_ack_pattern: got %b expected 010010", ack_bits); end
    vectors++; if (csb_bits !== 6'b001001) begin miscompares++; $display("FAIL b2b_csb_pattern: got %b expected 001001", csb_bits); end
  endtask

  task automatic test_rdbuf();
    int exp_cyc2, exp_csb2;
`ifdef SRAM_CTRL_RDBUF_EN
    exp_cyc2 = 2; exp_csb2 = 0;
`else
    exp_cyc2 = 3; exp_csb2 = 1;
`endif
    wb_xfer(32'h0100_0020, 32'hA5A5_A5A5, 1'b1, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    wb_xfer(32'h0100_0020, 32'h0, 1'b0, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (a_cyc !== 3) begin miscompares++; $display("FAIL buf_rd1_ack: got %0d expected 3", a_cyc); end
    vectors++; if (rd !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL buf_rd1_data: got %h expected a5a5a5a5", rd); end
    wb_xfer(32'h0100_0020, 32'h0, 1'b0, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (a_cyc !== exp_cyc2) begin miscompares++; $display("FAIL buf_rd2_ack: got %0d expected %0d", a_cyc, exp_cyc2); end
    vectors++; if (c_cnt !== exp_csb2) begin miscompares++; $display("FAIL buf_rd2_csb: got %0d expected %0d", c_cnt, exp_csb2); end
    vectors++; if (rd !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL buf_rd2_data: got %h expected a5a5a5a5", rd); end
    wb_xfer(32'h0100_0020, 32'h5A5A_0000, 1'b1, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    wb_xfer(32'h0100_0020, 32'h0, 1'b0, 4'hF, a_cyc, rd, c_cnt, l_addr, l_web, a_after);
    vectors++; if (a_cyc !== 3) begin miscompares++; $display("FAIL buf_rd3_ack: got %0d expected 3", a_cyc); end
    vectors++; if (c_cnt !== 1) begin miscompares++; $display("FAIL buf_rd3_csb: got %0d expected 1", c_cnt); end
    vectors++; if (rd !== 32'h5A5A_0000) begin miscompares++; $display("FAIL buf_rd3_data: got %h expected 5a5a0000", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_zero_sel();
    test_miss();
    test_reset_in_wait();
    test_stb_drop();
    test_back_to_back();
    test_rdbuf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
